// File: rtl/spike_rate_counter.sv
// spike_rate_counter
//
// Turns the motoneuron pool's spike level into spike counts. Each rising
// edge of spike_in counts once. Edges are added up over a programmable
// window of clk cycles. When the window ends, the count is published with a
// one-cycle strobe. A saturating running total is kept alongside.
//
// Optional feature: define SPIKE_ISI_EN to add an inter-spike-interval
// measurement on the isi_out / isi_valid ports.
//
// Parameters:
//   CW  width of the window accumulator, spike_count_out and total_spikes
//   LW  width of window_len and the window timer (and isi_out)
//
// Ports:
//   clk              block clock (the spike source runs on it too)
//   reset_sim_n      asynchronous active-low reset
//   spike_in         spike level, synchronous to clk
//   window_len       window length in clk cycles; 0 disables windowing
//   clear            synchronous clear of accumulator, timer and total
//   spike_edge       one-cycle pulse per detected spike (registered)
//   spike_count_out  spike count of the last completed window
//   count_valid      one-cycle strobe when spike_count_out updates
//   total_spikes     cumulative saturating spike count
//   isi_out          (SPIKE_ISI_EN) cycles between the last two spikes
//   isi_valid        (SPIKE_ISI_EN) one-cycle strobe when isi_out updates
module spike_rate_counter #(
  parameter int CW = 32,
  parameter int LW = 32
) (
  input  logic          clk,
  input  logic          reset_sim_n,
  input  logic          spike_in,
  input  logic [LW-1:0] window_len,
  input  logic          clear,
  output logic          spike_edge,
  output logic [CW-1:0] spike_count_out,
  output logic          count_valid,
`ifdef SPIKE_ISI_EN
  output logic [LW-1:0] isi_out,
  output logic          isi_valid,
`endif
  output logic [CW-1:0] total_spikes
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] CW_MAX = {CW{1'b1}};

  state_t        state_reg;
  logic          spike_d_reg;
  logic [CW-1:0] acc_reg;
  logic [LW-1:0] timer_reg;

  logic          spike_rise;
  logic [CW-1:0] acc_next;
  logic [CW-1:0] total_next;
  logic          window_close;

  // spike_d is 0 after reset, so a spike_in already high at release gives
  // one edge on the first evaluated cycle.
  assign spike_rise = spike_in & ~spike_d_reg;

  // Saturating increments: once at the maximum, further edges are ignored.
  assign acc_next   = (acc_reg == CW_MAX) ? acc_reg : acc_reg + CW'(spike_rise);
  assign total_next = (total_spikes == CW_MAX) ? total_spikes
                                               : total_spikes + CW'(spike_rise);

  // Compared against the live window_len, so shortening the window below
  // the elapsed time closes it on the current cycle. Only used in RUN, where
  // window_len is nonzero, so the subtraction cannot wrap.
  assign window_close = (timer_reg >= window_len - LW'(1));

  always_ff @(posedge clk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      state_reg       <= IDLE;
      spike_d_reg     <= 1'b0;
      acc_reg         <= '0;
      timer_reg       <= '0;
      spike_edge      <= 1'b0;
      spike_count_out <= '0;
      count_valid     <= 1'b0;
      total_spikes    <= '0;
    end else begin
      spike_d_reg <= spike_in;
      spike_edge  <= spike_rise;
      count_valid <= 1'b0;
      // Mode follows window_len directly: a nonzero length starts a window
      // next cycle with timer 0, a zero length drops the partial window.
      state_reg   <= (window_len == '0) ? IDLE : RUN;

      if (clear) begin
        // Clear wins over window close and counting; the edge of this
        // cycle is dropped and the last published count is kept.
        acc_reg      <= '0;
        timer_reg    <= '0;
        total_spikes <= '0;
      end else begin
        total_spikes <= total_next;
        case (state_reg)
          IDLE: begin
            acc_reg   <= '0;
            timer_reg <= '0;
          end
          RUN: begin
            if (window_len == '0) begin
              acc_reg   <= '0;
              timer_reg <= '0;
            end else if (window_close) begin
              // An edge on the closing cycle belongs to the closing window.
              spike_count_out <= acc_next;
              count_valid     <= 1'b1;
              acc_reg         <= '0;
              timer_reg       <= '0;
            end else begin
              acc_reg   <= acc_next;
              timer_reg <= timer_reg + LW'(1);
            end
          end
          default: begin
            acc_reg   <= '0;
            timer_reg <= '0;
          end
        endcase
      end
    end
  end

`ifdef SPIKE_ISI_EN
  localparam logic [LW-1:0] LW_MAX = {LW{1'b1}};

  logic [LW-1:0] isi_cnt_reg;
  logic          isi_armed_reg;

  // The interval counter restarts at 1 on each edge, so on the next edge it
  // holds the number of cycles between the two edges. The first edge after
  // reset or clear has no predecessor and only arms the measurement.
  always_ff @(posedge clk or negedge reset_sim_n) begin
    if (!reset_sim_n) begin
      isi_cnt_reg   <= '0;
      isi_armed_reg <= 1'b0;
      isi_out       <= '0;
      isi_valid     <= 1'b0;
    end else if (clear) begin
      isi_cnt_reg   <= '0;
      isi_armed_reg <= 1'b0;
      isi_out       <= '0;
      isi_valid     <= 1'b0;
    end else if (spike_rise) begin
      isi_cnt_reg   <= LW'(1);
      isi_armed_reg <= 1'b1;
      isi_valid     <= isi_armed_reg;
      if (isi_armed_reg) begin
        isi_out <= isi_cnt_reg;
      end
    end else begin
      isi_valid <= 1'b0;
      if (isi_cnt_reg != LW_MAX) begin
        isi_cnt_reg <= isi_cnt_reg + LW'(1);
      end
    end
  end
`endif

endmodule
